// File: rtl/gb_csr_ram_responder.sv
// rtl/gb_csr_ram_responder.sv - Ghostbus responder: CSR bank plus RAM window
// Decodes one aligned address window and returns read data a fixed number of cycles after the read strobe.
module gb_csr_ram_responder #(
    parameter logic [23:0] BASE_ADDR  = 24'h000100,
    parameter int          WIN_AW     = 6,
    parameter logic [31:0] ID_VALUE   = 32'h6b505201,
    parameter int          CTRL_DW    = 8,
    parameter int          RAM_AW     = 4,
    parameter int          RAM_DW     = 8,
    parameter int          READ_DELAY = 3
) (
    input  logic               gb_clk,
    input  logic               gb_rst,
    input  logic [23:0]        gb_addr,
    input  logic [31:0]        gb_wdata,
    input  logic               gb_wen,
    input  logic               gb_rstb,
    output logic [31:0]        gb_rdata,
    output logic [CTRL_DW-1:0] ctrl,
    output logic               strobe,
    input  logic [31:0]        status_in
);

    localparam logic [WIN_AW-1:0] OFF_ID      = WIN_AW'(0);
    localparam logic [WIN_AW-1:0] OFF_SCRATCH = WIN_AW'(1);
    localparam logic [WIN_AW-1:0] OFF_CTRL    = WIN_AW'(2);
    localparam logic [WIN_AW-1:0] OFF_STROBE  = WIN_AW'(3);
    localparam logic [WIN_AW-1:0] OFF_WRCNT   = WIN_AW'(4);
    localparam logic [WIN_AW-1:0] OFF_RDCNT   = WIN_AW'(5);
    localparam logic [WIN_AW-1:0] OFF_STATUS  = WIN_AW'(6);
    localparam int                RAM_WORDS   = 2 ** RAM_AW;

    logic              hit;
    logic [WIN_AW-1:0] off;
    logic              is_ram;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr;
    logic              rd;

    logic [31:0]        scratch_q, scratch_d;
    logic [CTRL_DW-1:0] ctrl_q, ctrl_d;
    logic               strobe_q, strobe_d;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic [15:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]        rd_data_d;
    logic [31:0]        pipe_q [READ_DELAY];
    logic [RAM_DW-1:0]  ram_q [RAM_WORDS];

    assign hit     = (gb_addr[23:WIN_AW] == BASE_ADDR[23:WIN_AW]);
    assign off     = gb_addr[WIN_AW-1:0];
    assign is_ram  = off[WIN_AW-1];
    assign ram_idx = off[RAM_AW-1:0];
    assign wr      = gb_wen & hit;
    assign rd      = gb_rstb & hit;

    // Read data is selected from pre-write state, giving read-before-write on collisions.
    always_comb begin
        rd_data_d = 32'h0;
        if (rd) begin
            if (is_ram) begin
                rd_data_d = 32'(ram_q[ram_idx]);
            end else begin
                case (off)
                    OFF_ID:      rd_data_d = ID_VALUE;
                    OFF_SCRATCH: rd_data_d = scratch_q;
                    OFF_CTRL:    rd_data_d = 32'(ctrl_q);
                    OFF_WRCNT:   rd_data_d = 32'(wr_cnt_q);
                    OFF_RDCNT:   rd_data_d = 32'(rd_cnt_q);
                    OFF_STATUS:  rd_data_d = status_in;
                    default:     rd_data_d = 32'h0;
                endcase
            end
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        strobe_d  = 1'b0;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (wr) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
            if (!is_ram) begin
                case (off)
                    OFF_SCRATCH: scratch_d = gb_wdata;
                    OFF_CTRL:    ctrl_d    = gb_wdata[CTRL_DW-1:0];
                    OFF_STROBE:  strobe_d  = 1'b1;
                    default:     ;
                endcase
            end
        end
        if (rd) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            scratch_q <= 32'h0;
            ctrl_q    <= '0;
            strobe_q  <= 1'b0;
            wr_cnt_q  <= 16'h0;
            rd_cnt_q  <= 16'h0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            strobe_q  <= strobe_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Idle stages carry zero so the output can be OR-combined with other responders.
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            for (int i = 0; i < READ_DELAY; i++) begin
                pipe_q[i] <= 32'h0;
            end
        end else begin
            pipe_q[0] <= rd_data_d;
            for (int i = 1; i < READ_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge gb_clk) begin
        if (wr && is_ram && !gb_rst) begin
            ram_q[ram_idx] <= gb_wdata[RAM_DW-1:0];
        end
    end

    assign gb_rdata = pipe_q[READ_DELAY-1];
    assign ctrl     = ctrl_q;
    assign strobe   = strobe_q;

endmodule

// File: tb/tb_gb_csr_ram_responder.sv
// tb/tb_gb_csr_ram_responder.sv - Self-checking bench for gb_csr_ram_responder
module tb_gb_csr_ram_responder;

    localparam logic [23:0] BASE   = 24'h000100;
    localparam logic [31:0] ID     = 32'h6b505201;
    localparam int          RDLY   = 3;
    localparam logic [31:0] STATUS = 32'h1234_5678;

    logic        gb_clk = 1'b0;
    logic        gb_rst;
    logic [23:0] gb_addr;
    logic [31:0] gb_wdata;
    logic        gb_wen;
    logic        gb_rstb;
    logic [31:0] gb_rdata;
    logic [7:0]  ctrl;
    logic        strobe;
    logic [31:0] status_in;

    int total = 0;
    int bad   = 0;

    logic [31:0] scratch_m;
    logic [7:0]  ctrl_m;
    logic [15:0] wr_cnt_m;
    logic [15:0] rd_cnt_m;
    logic [7:0]  ram_m [16];
    logic [31:0] exp_q [$];

    always #5 gb_clk = ~gb_clk;

    gb_csr_ram_responder dut (
        .gb_clk    (gb_clk),
        .gb_rst    (gb_rst),
        .gb_addr   (gb_addr),
        .gb_wdata  (gb_wdata),
        .gb_wen    (gb_wen),
        .gb_rstb   (gb_rstb),
        .gb_rdata  (gb_rdata),
        .ctrl      (ctrl),
        .strobe    (strobe),
        .status_in (status_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] o);
        if (o >= 6'd32) return {24'h0, ram_m[o[3:0]]};
        case (o)
            6'd0:    return ID;
            6'd1:    return scratch_m;
            6'd2:    return {24'h0, ctrl_m};
            6'd4:    return {16'h0, wr_cnt_m};
            6'd5:    return {16'h0, rd_cnt_m};
            6'd6:    return STATUS;
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: compute expectations from the model, drive, then check at the falling edge.
    task automatic tick(input logic rst, input logic wen, input logic rstb,
                        input logic [23:0] addr, input logic [31:0] wdata);
        logic        hit;
        logic [5:0]  o;
        logic [31:0] rexp;
        logic        sexp;
        hit  = ((addr >> 6) == (BASE >> 6));
        o    = addr[5:0];
        rexp = 32'h0;
        sexp = 1'b0;
        gb_rst   = rst;
        gb_wen   = wen;
        gb_rstb  = rstb;
        gb_addr  = addr;
        gb_wdata = wdata;
        if (rst) begin
            scratch_m = 32'h0;
            ctrl_m    = 8'h0;
            wr_cnt_m  = 16'h0;
            rd_cnt_m  = 16'h0;
            foreach (exp_q[i]) exp_q[i] = 32'h0;
        end else begin
            if (rstb && hit) begin
                rexp = model_read(o);
                rd_cnt_m = rd_cnt_m + 16'd1;
            end
            if (wen && hit) begin
                wr_cnt_m = wr_cnt_m + 16'd1;
                if (o >= 6'd32) ram_m[o[3:0]] = wdata[7:0];
                else if (o == 6'd1) scratch_m = wdata;
                else if (o == 6'd2) ctrl_m = wdata[7:0];
                else if (o == 6'd3) sexp = 1'b1;
            end
        end
        exp_q.push_back(rexp);
        @(posedge gb_clk);
        @(negedge gb_clk);
        check("rdata", gb_rdata, exp_q.pop_front());
        check("strobe", {31'h0, strobe}, {31'h0, sexp});
        check("ctrl", {24'h0, ctrl}, {24'h0, ctrl_m});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    endtask

    task automatic rd(input logic [5:0] o);
        tick(1'b0, 1'b0, 1'b1, BASE + {18'h0, o}, 32'h0);
    endtask

    task automatic wr(input logic [5:0] o, input logic [31:0] d);
        tick(1'b0, 1'b1, 1'b0, BASE + {18'h0, o}, d);
    endtask

    initial begin
        gb_rst = 1'b1; gb_wen = 1'b0; gb_rstb = 1'b0;
        gb_addr = 24'h0; gb_wdata = 32'h0; status_in = STATUS;
        for (int i = 0; i < RDLY - 1; i++) exp_q.push_back(32'h0);
        @(negedge gb_clk);
        tick(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);

        // ID and counters after reset
        rd(6'd5); rd(6'd4); rd(6'd0); idle(4);
        rd(6'd6); rd(6'd7); idle(3);

        // SCRATCH and CTRL
        wr(6'd1, 32'hA5A5_5A5A); wr(6'd2, 32'h0000_01FF);
        rd(6'd1); rd(6'd2); rd(6'd4); idle(3);
        check("ctrl_ff", {24'h0, ctrl}, 32'h0000_00FF);

        // back-to-back STROBE writes, STROBE reads 0, unmapped write counted
        wr(6'd3, 32'h1); wr(6'd3, 32'h1); rd(6'd3); wr(6'd9, 32'hFFFF_FFFF); rd(6'd4); idle(3);

        // RAM fill and streaming readback, plus alias of index 0
        for (int i = 0; i < 16; i++) wr(6'd32 + 6'(i), 32'hE0 + i);
        for (int i = 0; i < 16; i++) rd(6'd32 + 6'(i));
        rd(6'd48); idle(3);
        check("ram_alias", {24'h0, ram_m[0]}, 32'h0000_00E0);

        // read-before-write collision on SCRATCH
        wr(6'd1, 32'h11);
        tick(1'b0, 1'b1, 1'b1, BASE + 24'd1, 32'h22);
        rd(6'd1); idle(3);

        // misses are ignored
        tick(1'b0, 1'b0, 1'b1, BASE + 24'h40, 32'h0);
        tick(1'b0, 1'b1, 1'b0, BASE + 24'h41, 32'h99);
        rd(6'd5); rd(6'd4); rd(6'd1); idle(3);

        // reset with a read in flight
        rd(6'd1);
        tick(1'b1, 1'b0, 1'b1, BASE + 24'd1, 32'h0);
        idle(3);
        rd(6'd2); rd(6'd4); rd(6'd5); idle(3);
        check("ctrl_zero", {24'h0, ctrl}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
